// File: rtl/i2c_cmd_sequencer_pkg.sv
// Shared definitions for the I2C command sequencer: op codes, FSM states
// and the helper that builds the 9-bit word for the bit engine.
package i2c_cmd_sequencer_pkg;

  typedef enum logic [1:0] {
    k_op_start = 2'd0,
    k_op_write = 2'd1,
    k_op_read  = 2'd2,
    k_op_stop  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    s_idle,
    s_issue,
    s_wait,
    s_resp
  } seq_state_e;

  localparam int unsigned k_cmd_w   = 10;
  localparam logic [8:0]  k_tx_idle = 9'h1FF;

  // READ: master ACK/NACK bit on top, SDA released for the data phase.
  // WRITE: ACK slot released, byte below it. START/STOP: all released.
  function automatic logic [8:0] tx_word(input op_e op, input logic [7:0] data);
    case (op)
      k_op_write: return {1'b1, data};
      k_op_read:  return {data[0], 8'hFF};
      default:    return k_tx_idle;
    endcase
  endfunction

endpackage

// File: rtl/i2c_cmd_sequencer_fifo.sv
// Synchronous FIFO holding {op, data} commands ahead of the sequencer FSM.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module i2c_sync_fifo #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] dout
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             push_en;
  logic             pop_en;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign push_en = push && !full;
  assign pop_en  = pop && !empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  // Pointer bookkeeping; both wrap naturally through the extra MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (pop_en)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  // Storage write; contents need no reset since empty masks them.
  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/i2c_cmd_sequencer.sv
// Command front-end for the I2C master core: buffers host commands, issues
// them one at a time to the bit engine and returns one response per command.
// After a NACKed WRITE, commands up to the next STOP are answered as aborted.
module i2c_cmd_sequencer
  import i2c_cmd_sequencer_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_ack,
  output logic       rsp_abort,
  output logic       m_valid,
  input  logic       m_ready,
  output logic [1:0] m_op,
  output logic [8:0] m_tx,
  input  logic       m_done,
  input  logic [7:0] m_rx,
  input  logic       m_ack,
  output logic       busy
);

  seq_state_e         state;
  logic               abort_flag;
  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_pop;
  logic [k_cmd_w-1:0] fifo_dout;
  op_e                head_op;
  logic [7:0]         head_data;

  assign cmd_ready = !fifo_full;
  assign fifo_pop  = (state == s_idle) && !fifo_empty;
  assign head_op   = op_e'(fifo_dout[9:8]);
  assign head_data = fifo_dout[7:0];
  assign busy      = !fifo_empty || (state != s_idle);

  i2c_sync_fifo #(
    .WIDTH (k_cmd_w),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (cmd_valid),
    .din   ({cmd_op, cmd_data}),
    .pop   (fifo_pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .dout  (fifo_dout)
  );

  // Sequencer FSM with registered core request and response outputs.
  // m_op doubles as the holding register for the command in flight; it is
  // left untouched on aborted commands since those never reach the core.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= s_idle;
      abort_flag <= 1'b0;
      m_valid    <= 1'b0;
      m_op       <= k_op_start;
      m_tx       <= k_tx_idle;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_ack    <= 1'b1;
      rsp_abort  <= 1'b0;
    end else begin
      case (state)
        s_idle: begin
          if (!fifo_empty) begin
            if (abort_flag && head_op != k_op_stop) begin
              rsp_valid <= 1'b1;
              rsp_data  <= '0;
              rsp_ack   <= 1'b1;
              rsp_abort <= 1'b1;
              state     <= s_resp;
            end else begin
              m_valid <= 1'b1;
              m_op    <= head_op;
              m_tx    <= tx_word(head_op, head_data);
              state   <= s_issue;
            end
          end
        end
        s_issue: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            state   <= s_wait;
          end
        end
        s_wait: begin
          if (m_done) begin
            rsp_valid <= 1'b1;
            rsp_abort <= 1'b0;
            rsp_data  <= (m_op == k_op_read) ? m_rx : '0;
            rsp_ack   <= (m_op == k_op_write) ? m_ack : 1'b1;
            if (m_op == k_op_write && !m_ack) abort_flag <= 1'b1;
            if (m_op == k_op_stop) abort_flag <= 1'b0;
            state <= s_resp;
          end
        end
        s_resp: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= s_idle;
          end
        end
        default: state <= s_idle;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Directed bench for i2c_cmd_sequencer with a small bit-engine model.
module tb_i2c_cmd_sequencer;

  localparam logic [1:0] OP_START = 2'd0;
  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_READ  = 2'd2;
  localparam logic [1:0] OP_STOP  = 2'd3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_ack;
  logic       rsp_abort;
  logic       m_valid;
  logic       m_ready;
  logic [1:0] m_op;
  logic [8:0] m_tx;
  logic       m_done;
  logic [7:0] m_rx;
  logic       m_ack;
  logic       busy;

  always #5 clk = ~clk;

  i2c_cmd_sequencer #(.DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_ack   (rsp_ack),
    .rsp_abort (rsp_abort),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_op      (m_op),
    .m_tx      (m_tx),
    .m_done    (m_done),
    .m_rx      (m_rx),
    .m_ack     (m_ack),
    .busy      (busy)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  logic [1:0]  iss_op [64];
  logic [8:0]  iss_tx [64];
  int unsigned iss_cnt = 0;
  logic [7:0]  r_data [64];
  logic        r_ack [64];
  logic        r_abort [64];
  int unsigned rsp_cnt = 0;
  logic        ack_tab [64];
  logic [7:0]  rx_tab [64];
  logic        core_stall = 1'b0;
  logic        core_hold  = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Bit-engine model: accepts requests, answers with m_done one cycle later.
  initial begin : core_model
    bit          pend;
    int unsigned pidx;
    pend = 0; pidx = 0;
    m_ready = 1'b0; m_done = 1'b0; m_rx = '0; m_ack = 1'b0;
    forever begin
      @(negedge clk);
      m_done = 1'b0;
      if (!rst_n) pend = 0;
      else if (pend && !core_hold) begin
        m_done = 1'b1;
        m_rx   = rx_tab[pidx];
        m_ack  = ack_tab[pidx];
        pend   = 0;
      end
      m_ready = !core_stall;
      if (rst_n && m_valid && m_ready && iss_cnt < 64) begin
        iss_op[iss_cnt] = m_op;
        iss_tx[iss_cnt] = m_tx;
        pidx = iss_cnt;
        iss_cnt++;
        pend = 1;
      end
    end
  end

  // Response collector: logs every accepted response.
  initial begin : rsp_collector
    forever begin
      @(negedge clk);
      if (rst_n && rsp_valid && rsp_ready && rsp_cnt < 64) begin
        r_data[rsp_cnt]  = rsp_data;
        r_ack[rsp_cnt]   = rsp_ack;
        r_abort[rsp_cnt] = rsp_abort;
        rsp_cnt++;
      end
    end
  end

  task automatic push(input logic [1:0] op, input logic [7:0] d);
    int unsigned n = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
    @(negedge clk);
    while (!cmd_ready && n < 200) begin @(negedge clk); n++; end
    if (!cmd_ready) check("push_wait", cmd_ready, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int unsigned target);
    int unsigned n = 0;
    while (rsp_cnt < target && n < 400) begin @(posedge clk); n++; end
    #1;
    check("rsp_wait", rsp_cnt >= target, 1);
  endtask

  task automatic settle();
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin : main
    int unsigned bi;
    int unsigned br;
    int unsigned ic;
    int unsigned n;
    logic [7:0]  v;
    logic [7:0]  hd;
    logic        ha;
    logic        hab;
    logic        stable;

    for (int i = 0; i < 64; i++) begin ack_tab[i] = 1'b1; rx_tab[i] = 8'h00; end
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_data = '0; rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_tx", m_tx, 9'h1FF);
    check("rst_busy", busy, 0);
    check("rst_m_op", m_op, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_ack", rsp_ack, 1);
    check("rst_rsp_abort", rsp_abort, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // START, WRITE A4, STOP all acknowledged
    bi = iss_cnt; br = rsp_cnt;
    push(OP_START, 8'h00);
    push(OP_WRITE, 8'hA4);
    push(OP_STOP, 8'h00);
    wait_rsp(br + 3);
    check("seq_issued", iss_cnt - bi, 3);
    check("seq_op0", iss_op[bi], OP_START);
    check("seq_tx0", iss_tx[bi], 9'h1FF);
    check("seq_op1", iss_op[bi+1], OP_WRITE);
    check("seq_tx1", iss_tx[bi+1], 9'h1A4);
    check("seq_op2", iss_op[bi+2], OP_STOP);
    check("seq_tx2", iss_tx[bi+2], 9'h1FF);
    for (int k = 0; k < 3; k++) begin
      check("seq_ack", r_ack[br+k], 1);
      check("seq_abort", r_abort[br+k], 0);
      check("seq_data", r_data[br+k], 0);
    end
    settle();

    // READ (last) with cycle-exact request latency
    bi = iss_cnt; br = rsp_cnt;
    rx_tab[bi] = 8'h5C;
    cmd_valid = 1'b1; cmd_op = OP_READ; cmd_data = 8'h01;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("lat_n1_m_valid", m_valid, 0);
    check("lat_n1_busy", busy, 1);
    @(posedge clk); #1;
    check("lat_n2_m_valid", m_valid, 1);
    check("rd_m_op", m_op, OP_READ);
    check("rd_m_tx", m_tx, 9'h1FF);
    wait_rsp(br + 1);
    check("rd_data", r_data[br], 8'h5C);
    check("rd_ack", r_ack[br], 1);
    check("rd_abort", r_abort[br], 0);
    settle();

    // NACKed WRITE aborts the next WRITE until STOP
    bi = iss_cnt; br = rsp_cnt;
    ack_tab[bi] = 1'b0;
    push(OP_WRITE, 8'h33);
    push(OP_WRITE, 8'h10);
    push(OP_STOP, 8'h00);
    wait_rsp(br + 3);
    check("nack_issued", iss_cnt - bi, 2);
    check("nack_tx0", iss_tx[bi], 9'h133);
    check("nack_op1", iss_op[bi+1], OP_STOP);
    check("nack_r0_ack", r_ack[br], 0);
    check("nack_r0_abort", r_abort[br], 0);
    check("nack_r1_abort", r_abort[br+1], 1);
    check("nack_r1_ack", r_ack[br+1], 1);
    check("nack_r1_data", r_data[br+1], 0);
    check("nack_r2_abort", r_abort[br+2], 0);
    check("nack_r2_ack", r_ack[br+2], 1);
    settle();
    push(OP_WRITE, 8'h55);
    wait_rsp(br + 4);
    check("clr_issued", iss_cnt - bi, 3);
    check("clr_tx", iss_tx[bi+2], 9'h155);
    check("clr_abort", r_abort[br+3], 0);
    settle();

    // Core stalled: one held command plus a full FIFO back-pressures the host
    bi = iss_cnt; br = rsp_cnt;
    core_stall = 1'b1;
    for (int k = 0; k < 5; k++) begin
      v = 8'(8'h11 * (k + 1));
      push(OP_WRITE, v);
    end
    check("full_cmd_ready", cmd_ready, 0);
    check("full_m_valid", m_valid, 1);
    check("full_m_tx_held", m_tx, 9'h111);
    check("full_no_issue", iss_cnt - bi, 0);
    core_stall = 1'b0;
    wait_rsp(br + 5);
    check("drain_issued", iss_cnt - bi, 5);
    for (int k = 0; k < 5; k++) begin
      v = 8'(8'h11 * (k + 1));
      check("drain_order_tx", iss_tx[bi+k], {1'b1, v});
      check("drain_abort", r_abort[br+k], 0);
    end
    settle();

    // Response back-pressure holds everything still
    bi = iss_cnt; br = rsp_cnt;
    rsp_ready = 1'b0;
    push(OP_WRITE, 8'h77);
    push(OP_READ, 8'h00);
    n = 0;
    while (!rsp_valid && n < 50) begin @(posedge clk); #1; n++; end
    check("hold_rsp_valid", rsp_valid, 1);
    hd = rsp_data; ha = rsp_ack; hab = rsp_abort; ic = iss_cnt;
    stable = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      if (rsp_valid !== 1'b1 || rsp_data !== hd || rsp_ack !== ha ||
          rsp_abort !== hab || m_valid !== 1'b0) stable = 1'b0;
    end
    check("hold_stable", stable, 1);
    check("hold_no_issue", iss_cnt, ic);
    check("hold_busy", busy, 1);
    check("hold_ack", ha, 1);
    check("hold_data", hd, 0);
    rsp_ready = 1'b1;
    wait_rsp(br + 2);
    check("hold_issued", iss_cnt - bi, 2);
    check("hold_rd_op", iss_op[bi+1], OP_READ);
    check("hold_rd_tx", iss_tx[bi+1], 9'h0FF);
    settle();

    // Asynchronous reset while waiting on the core
    bi = iss_cnt;
    core_hold = 1'b1;
    push(OP_WRITE, 8'h99);
    n = 0;
    while (iss_cnt == bi && n < 50) begin @(posedge clk); #1; n++; end
    repeat (2) @(posedge clk);
    #1;
    check("wait_busy", busy, 1);
    check("wait_m_tx", m_tx, 9'h199);
    rst_n = 1'b0;
    #1;
    check("arst_m_valid", m_valid, 0);
    check("arst_rsp_valid", rsp_valid, 0);
    check("arst_m_tx", m_tx, 9'h1FF);
    check("arst_m_op", m_op, 0);
    check("arst_busy", busy, 0);
    check("arst_cmd_ready", cmd_ready, 1);
    core_hold = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    br = rsp_cnt;
    push(OP_STOP, 8'h00);
    wait_rsp(br + 1);
    check("post_rst_ack", r_ack[br], 1);
    check("post_rst_abort", r_abort[br], 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
